// File: rtl/fifo_flags.sv
// fifo_flags: single-clock synchronous FIFO with first-word-fall-through output,
// occupancy count, almost-full/almost-empty flags and sticky error flags.
// Works for any depth of 2 or more, including non-power-of-two depths.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   clr          synchronous flush (pointers, count and error flags)
//   din / enq    write data / write request
//   full_n       1 = space available
//   dout / deq   head entry (valid while empty_n=1) / pop request
//   empty_n      1 = data available
//   count        current occupancy, 0..FIFO_DEPTH
//   almost_full  count >= AFULL_THRESH
//   almost_empty count <= AEMPTY_THRESH
//   overflow     sticky: an enq was dropped because the FIFO was full
//   underflow    sticky: a deq arrived while the FIFO was empty
module fifo_flags #(
    parameter int DATA_WIDTH    = 8,
    parameter int FIFO_DEPTH    = 4,
    parameter int AFULL_THRESH  = FIFO_DEPTH - 1,
    parameter int AEMPTY_THRESH = 1,
    localparam int COUNT_WIDTH  = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    input  logic [DATA_WIDTH-1:0]  din,
    input  logic                   enq,
    output logic                   full_n,
    output logic [DATA_WIDTH-1:0]  dout,
    input  logic                   deq,
    output logic                   empty_n,
    output logic [COUNT_WIDTH-1:0] count,
    output logic                   almost_full,
    output logic                   almost_empty,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [PTR_W-1:0]       PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [COUNT_WIDTH-1:0] CNT_FULL = COUNT_WIDTH'(FIFO_DEPTH);
    localparam logic [COUNT_WIDTH-1:0] CNT_AF   = COUNT_WIDTH'(AFULL_THRESH);
    localparam logic [COUNT_WIDTH-1:0] CNT_AE   = COUNT_WIDTH'(AEMPTY_THRESH);

    logic [DATA_WIDTH-1:0]  mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr, rd_ptr;
    logic [COUNT_WIDTH-1:0] cnt;
    logic                   ovf_q, udf_q;

    logic is_full, is_empty;
    logic wr_en, rd_en;
    logic mem_we;

    assign is_full  = (cnt == CNT_FULL);
    assign is_empty = (cnt == '0);

    // A full FIFO still takes a write when the head is popped in the same
    // cycle: the freed slot receives the new word. clr wins over both.
    assign wr_en = enq & (~is_full | deq) & ~clr;
    assign rd_en = deq & ~is_empty & ~clr;

    // Storage has no reset, so gate with rst_n to keep a write on the edge
    // coincident with reset from landing in the array.
    assign mem_we = wr_en & rst_n;

    always_ff @(posedge clk) begin
        if (mem_we) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ovf_q  <= 1'b0;
            udf_q  <= 1'b0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ovf_q  <= 1'b0;
            udf_q  <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;

            // Simultaneous write and read leave occupancy unchanged.
            if (wr_en && !rd_en)      cnt <= cnt + 1'b1;
            else if (rd_en && !wr_en) cnt <= cnt - 1'b1;

            if (enq && is_full && !deq) ovf_q <= 1'b1;
            if (deq && is_empty)        udf_q <= 1'b1;
        end
    end

    // FWFT: head entry is visible combinationally from the read pointer.
    assign dout = mem[rd_ptr];

    // Status is derived from registered count only, so there is no
    // combinational path from enq/deq to any flag.
    assign count        = cnt;
    assign full_n       = ~is_full;
    assign empty_n      = ~is_empty;
    assign almost_full  = (cnt >= CNT_AF);
    assign almost_empty = (cnt <= CNT_AE);
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

endmodule

// File: tb/tb_fifo_flags.sv
module tb_fifo_flags;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // DUT A: depth 3, width 4, default thresholds (AF=2, AE=1)
    logic       clr3 = 1'b0, enq3 = 1'b0, deq3 = 1'b0;
    logic [3:0] din3 = '0;
    logic       full_n3, empty_n3, af3, ae3, ovf3, udf3;
    logic [3:0] dout3;
    logic [1:0] cnt3;

    // DUT B: depth 5, width 4, AF=4, AE=1
    logic       clr5 = 1'b0, enq5 = 1'b0, deq5 = 1'b0;
    logic [3:0] din5 = '0;
    logic       full_n5, empty_n5, af5, ae5, ovf5, udf5;
    logic [3:0] dout5;
    logic [2:0] cnt5;

    fifo_flags #(.DATA_WIDTH(4), .FIFO_DEPTH(3)) u3 (
        .clk(clk), .rst_n(rst_n), .clr(clr3), .din(din3), .enq(enq3),
        .full_n(full_n3), .dout(dout3), .deq(deq3), .empty_n(empty_n3),
        .count(cnt3), .almost_full(af3), .almost_empty(ae3),
        .overflow(ovf3), .underflow(udf3)
    );

    fifo_flags #(.DATA_WIDTH(4), .FIFO_DEPTH(5), .AFULL_THRESH(4), .AEMPTY_THRESH(1)) u5 (
        .clk(clk), .rst_n(rst_n), .clr(clr5), .din(din5), .enq(enq5),
        .full_n(full_n5), .dout(dout5), .deq(deq5), .empty_n(empty_n5),
        .count(cnt5), .almost_full(af5), .almost_empty(ae5),
        .overflow(ovf5), .underflow(udf5)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge, sample 1ns later, then return inputs to idle.
    task automatic tick();
        @(posedge clk);
        #1;
        enq3 = 1'b0; deq3 = 1'b0; clr3 = 1'b0;
        enq5 = 1'b0; deq5 = 1'b0; clr5 = 1'b0;
    endtask

    task automatic push3(input logic [3:0] d);
        din3 = d; enq3 = 1'b1; tick();
    endtask

    logic [5:0] ae_tab;
    logic [5:0] af_tab;
    logic [3:0] exp_d;

    initial begin
        ae_tab = 6'b000011;   // almost_empty expected at counts 0,1
        af_tab = 6'b110000;   // almost_full expected at counts 4,5

        // ---------------- reset state ----------------
        #12;
        chk("rst_empty_n",  empty_n3, 0);
        chk("rst_full_n",   full_n3,  1);
        chk("rst_count",    cnt3,     0);
        chk("rst_aempty",   ae3,      1);
        chk("rst_afull",    af3,      0);
        chk("rst_ovf",      ovf3,     0);
        chk("rst_udf",      udf3,     0);
        chk("rst5_count",   cnt5,     0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // ---------------- basic enq/deq ----------------
        push3(4'hC);
        chk("b_cnt1",  cnt3,     1);
        chk("b_dout1", dout3,    4'hC);
        chk("b_ne1",   empty_n3, 1);
        push3(4'hA);
        chk("b_cnt2",  cnt3,  2);
        chk("b_dout2", dout3, 4'hC);
        chk("b_af2",   af3,   1);
        deq3 = 1'b1; tick();
        chk("b_cnt3",  cnt3,  1);
        chk("b_dout3", dout3, 4'hA);
        deq3 = 1'b1; tick();
        chk("b_cnt4",  cnt3,     0);
        chk("b_ne4",   empty_n3, 0);

        // ---------------- overflow ----------------
        push3(4'h1);
        push3(4'h2);
        push3(4'h3);
        chk("o_full_n", full_n3, 0);
        chk("o_cnt3",   cnt3,    3);
        push3(4'h4);
        chk("o_cnt",    cnt3,    3);
        chk("o_ovf",    ovf3,    1);
        for (int i = 1; i <= 3; i++) begin
            exp_d = 4'(i);
            chk("o_drain", dout3, exp_d);
            deq3 = 1'b1; tick();
        end
        chk("o_empty", empty_n3, 0);
        chk("o_ovf_sticky", ovf3, 1);

        clr3 = 1'b1; tick();
        chk("c_ovf_clr", ovf3, 0);

        // ---------------- full with enq & deq ----------------
        push3(4'h1);
        push3(4'h2);
        push3(4'h3);
        din3 = 4'h5; enq3 = 1'b1; deq3 = 1'b1; tick();
        chk("fd_cnt",    cnt3,    3);
        chk("fd_full_n", full_n3, 0);
        chk("fd_ovf",    ovf3,    0);
        chk("fd_d0", dout3, 4'h2); deq3 = 1'b1; tick();
        chk("fd_d1", dout3, 4'h3); deq3 = 1'b1; tick();
        chk("fd_d2", dout3, 4'h5); deq3 = 1'b1; tick();
        chk("fd_cnt0", cnt3, 0);

        // ---------------- underflow ----------------
        deq3 = 1'b1; tick();
        chk("u_udf",  udf3, 1);
        chk("u_cnt0", cnt3, 0);
        din3 = 4'h7; enq3 = 1'b1; deq3 = 1'b1; tick();
        chk("u_cnt1", cnt3,  1);
        chk("u_dout", dout3, 4'h7);
        chk("u_udf2", udf3,  1);
        deq3 = 1'b1; tick();
        chk("u_udf3", udf3,  1);
        clr3 = 1'b1; tick();
        chk("u_udf_clr", udf3, 0);

        // ---------------- thresholds (depth 5) ----------------
        chk("t_cnt0_ae", ae5, ae_tab[0]);
        chk("t_cnt0_af", af5, af_tab[0]);
        for (int i = 1; i <= 5; i++) begin
            din5 = 4'(i + 8); enq5 = 1'b1; tick();
            chk("t_fill_cnt", cnt5, i);
            chk("t_fill_ae",  ae5,  ae_tab[i]);
            chk("t_fill_af",  af5,  af_tab[i]);
        end
        chk("t_full_n", full_n5, 0);
        for (int i = 4; i >= 0; i--) begin
            exp_d = 4'(13 - i);   // 9..13 popped in order
            chk("t_drain_d", dout5, exp_d);
            deq5 = 1'b1; tick();
            chk("t_drain_cnt", cnt5, i);
            chk("t_drain_ae",  ae5,  ae_tab[i]);
            chk("t_drain_af",  af5,  af_tab[i]);
        end

        // ---------------- clr overrides enq ----------------
        push3(4'h1);
        push3(4'h2);
        push3(4'h3);
        push3(4'h4);
        deq3 = 1'b1; tick();
        chk("k_cnt2", cnt3, 2);
        chk("k_ovf1", ovf3, 1);
        din3 = 4'h9; enq3 = 1'b1; clr3 = 1'b1; tick();
        chk("k_cnt0", cnt3,     0);
        chk("k_ne",   empty_n3, 0);
        chk("k_ovf0", ovf3,     0);
        push3(4'h6);
        chk("k_cnt1", cnt3,  1);
        chk("k_dout", dout3, 4'h6);

        // ---------------- async reset mid-fill ----------------
        push3(4'h8);
        chk("r_cnt2", cnt3, 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("r_cnt0", cnt3,     0);
        chk("r_ne",   empty_n3, 0);
        chk("r_fn",   full_n3,  1);
        chk("r_ae",   ae3,      1);
        // enq held across an edge while in reset must not be committed
        din3 = 4'hE; enq3 = 1'b1;
        @(posedge clk); #1;
        enq3 = 1'b0;
        chk("r_hold_cnt", cnt3, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("r_after_cnt", cnt3,     0);
        chk("r_after_ne",  empty_n3, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout total=%0d", total);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fifo_flags.md
Name: fifo_flags

Overview:
- Parametrised successor to the team's basic `fifo`: a synchronous single-clock FIFO with enq/deq handshake.
- Supports any depth of 2 or more, including non-power-of-two (pointers wrap at DEPTH-1).
- Adds first-word-fall-through output, occupancy count, almost-full/almost-empty flags and sticky overflow/underflow error flags.
- Sits between producer and consumer pipeline stages as the standard elastic buffer.

Parameters:
- DATA_WIDTH, 8, width of din/dout in bits.
- FIFO_DEPTH, 4, number of entries; legal range >= 2; need not be a power of two.
- AFULL_THRESH, FIFO_DEPTH-1, almost_full asserts when count >= AFULL_THRESH; range 1..FIFO_DEPTH.
- AEMPTY_THRESH, 1, almost_empty asserts when count <= AEMPTY_THRESH; range 0..FIFO_DEPTH-1.
- COUNT_WIDTH, $clog2(FIFO_DEPTH+1), width of the count output. Derived; not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- clr  input  1  synchronous flush; empties the FIFO and clears error flags.
- din  input  DATA_WIDTH  write data.
- enq  input  1  write request.
- full_n  output  1  1 = space available.
- dout  output  DATA_WIDTH  head entry; valid while empty_n=1 (FWFT).
- deq  input  1  read request; pops the head entry.
- empty_n  output  1  1 = data available.
- count  output  COUNT_WIDTH  current occupancy, 0..FIFO_DEPTH.
- almost_full  output  1  count >= AFULL_THRESH.
- almost_empty  output  1  count <= AEMPTY_THRESH.
- overflow  output  1  sticky: an enq was dropped.
- underflow  output  1  sticky: a deq arrived while empty.

Behaviour:
- Reset:
  - Async assert of rst_n=0 immediately clears pointers, count, overflow and underflow.
  - Resulting outputs: empty_n=0, full_n=1, count=0, almost_empty=1, almost_full=0 (AFULL_THRESH>=1).
  - dout is don't-care while empty; storage is not reset.
  - Deassertion takes effect at the next clk edge.
- Storage: FIFO_DEPTH x DATA_WIDTH array; wr_ptr and rd_ptr wrap from FIFO_DEPTH-1 to 0. An explicit count register disambiguates full from empty.
- Status outputs:
  - full_n = (count != FIFO_DEPTH); empty_n = (count != 0).
  - almost_full and almost_empty are comparisons on the count register only; no combinational path from enq/deq.
- Accept rules, evaluated on the rising edge:
  - Write accepted when enq & (full_n | deq).
  - Read accepted when deq & empty_n.
- Full FIFO with enq & deq: both accepted. Head pops, new data is written into the freed slot, count stays FIFO_DEPTH, no overflow.
- Empty FIFO with enq & deq: write accepted, read rejected. underflow sets; count becomes 1; dout shows the new data one cycle later (no same-cycle bypass).
- Error flags:
  - enq while full without deq: data dropped, no state change except overflow<=1.
  - deq while empty: underflow<=1.
  - Both flags stay set until clr or reset.
- Count update: +1 on write only, -1 on read only, unchanged on both or neither. Never exceeds FIFO_DEPTH, never below 0.
- FWFT timing:
  - dout = mem[rd_ptr] combinationally.
  - Data written at edge N appears on dout after edge N when the FIFO was empty (latency 1 cycle).
  - After an accepted deq, dout shows the next entry after the same edge.
- clr (synchronous):
  - At the edge, resets pointers, count, overflow and underflow; overrides enq/deq in the same cycle (the write is not stored).
  - Outputs match reset values after that edge.
- Reset mid-operation: all contents are discarded; no partial write is committed on the edge coincident with rst_n=0.

Test Plan:
- DEPTH=3, WIDTH=4: reset, enq 0xC, then enq 0xA, then deq twice -> dout=C after first write. count goes 1,2,1,0. dout=A after first deq. empty_n=0 after second deq.
- DEPTH=3: enq 1,2,3 then enq 4 with deq=0 -> full_n=0 after third write. 4 dropped; overflow=1; count stays 3. Drain yields 1,2,3.
- DEPTH=3 full: enq 5 & deq in the same cycle -> count stays 3, no overflow. Drain order 2,3,5; pointers wrap correctly.
- Empty FIFO: deq alone, then enq 7 & deq together -> underflow=1. count=1; dout=7 next cycle. underflow stays 1 until clr.
- DEPTH=5, AFULL_THRESH=4, AEMPTY_THRESH=1: fill 0..5 then drain -> almost_empty=1 at counts 0,1. almost_full=1 at counts 4,5. Flags exact at each boundary.
- FIFO at count 2 with overflow=1: pulse clr together with enq 9 -> next cycle count=0, empty_n=0, overflow=0, 9 not stored. Async rst_n pulse mid-fill gives the same result immediately.
